sample_framer: RTL and testbench
================================

Name: sample_framer

Overview:
Serial-to-parallel frame assembler directly upstream of the FFT bit-reversal reorder stage. It accepts one WIDTH-bit sample per cycle over a valid/ready stream and packs SAMPLES consecutive samples into a natural-order frame array. It then presents the frame with a valid/ready handshake, so the reorder stage can consume whole frames. The design is two-deep (fill buffer plus output register) to sustain one sample per clock.

Parameters:
SAMPLES, 8, frame length; power of two, at least 2 (FFT size)
WIDTH, 16, bits per sample

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  framer can accept a sample this cycle
in_sample  input  WIDTH  sample data
out_valid  output  1  frame_data holds a complete frame
out_ready  input  1  downstream accepts the frame
frame_data  output  WIDTH x SAMPLES (unpacked array [SAMPLES-1:0])  frame; index 0 = first sample accepted
fill_level  output  $clog2(SAMPLES)+1  samples currently in the fill buffer (0..SAMPLES)

Interface decided: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async assert, registers cleared immediately):
  - cnt=0, out_valid=0, frame_data all zero, fill buffer zero, in_ready=1, fill_level=0.
  - Reset mid-frame discards the partial frame and any held or presented frame.
- States, encoded by cnt:
  - FILLING: cnt < SAMPLES.
  - HELD: cnt == SAMPLES.
- in_ready = (cnt < SAMPLES). This is combinational from state only and does not depend on in_valid or out_ready.
- Accept = in_valid & in_ready. On accept, fill_buf[cnt] <= in_sample and cnt increments.
- Output slot is free when !out_valid | out_ready.
- Completing accept (cnt == SAMPLES-1 and accept):
  - If slot free: frame_data <= fill_buf with the new sample at index SAMPLES-1; out_valid <= 1; cnt <= 0.
  - Else: cnt <= SAMPLES (HELD).
- HELD: when the slot is free, transfer fill_buf to frame_data, out_valid <= 1, cnt <= 0. HELD lasts at least one cycle.
- Output handshake: out_valid & out_ready with no transfer that cycle gives out_valid <= 0. A simultaneous consume and transfer keeps out_valid=1 with the new data.
- frame_data is stable while out_valid=1 and out_ready=0.
- Latency: last sample accepted at cycle t gives out_valid=1 at t+1.
- Throughput: with out_ready held at 1, a frame is emitted every SAMPLES cycles with no bubble.
- fill_level = cnt, registered.
- in_valid with in_ready=0: the sample is not taken. Upstream holds it.

Optional Feature:
SAMPLE_FRAMER_FLUSH_EN
- Defined: adds port flush (input, 1). A flush in FILLING with an effective count > 0 pads the remaining entries with zero and completes the frame, following the same slot-free/HELD rules.
  - A sample accepted in the same cycle is stored first and counts toward the frame.
  - Flush with effective count 0, or while HELD, is ignored.
  - Padding uses zeros, never stale buffer contents.
- Undefined: no flush port. Frames complete only on SAMPLES accepts.

Decomposition:
- Shared package fft_pkg:
  - localparams FFT_SAMPLES, FFT_WIDTH.
  - typedef sample_t = logic [FFT_WIDTH-1:0].
  - typedef frame_t = sample_t [FFT_SAMPLES-1:0].
  - CNT_W = $clog2(FFT_SAMPLES)+1.
- No sub-module needed. The fill buffer and the output register are each a single always_ff block.

Test Plan (SAMPLES=4, WIDTH=8):
- Reset then idle: out_valid=0, in_ready=1, fill_level=0, frame_data all 0x00.
- Stream 0x10,0x11,0x12,0x13 on consecutive cycles with out_ready=1: out_valid=1 the cycle after 0x13; frame_data[0..3]=10,11,12,13; then out_valid=0.
- Continuous stream 0x00..0x0B with out_ready=1: three frames, out_valid high every 4th cycle, in_ready never drops.
- out_ready=0 while streaming 8 samples:
  - Frame 1 is held.
  - After the 4th sample of frame 2, in_ready=0 and fill_level=4.
  - Raise out_ready: frame 1 is consumed and frame 2 appears the next cycle; in_ready returns to 1.
- Async reset asserted after 2 samples: outputs clear immediately. The next 4 samples 0xA0..0xA3 give frame A0,A1,A2,A3 with no residue.
- FLUSH_EN: samples 0x21,0x22 then flush: frame = 21,22,00,00 with out_valid the next cycle. Flush at fill_level=0 gives no frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT front-end types: frame geometry, sample/frame typedefs and fill-counter width.
package fft_pkg;

    localparam int FFT_SAMPLES = 8;
    localparam int FFT_WIDTH   = 16;
    localparam int CNT_W       = $clog2(FFT_SAMPLES) + 1;

    typedef logic [FFT_WIDTH-1:0]    sample_t;
    typedef sample_t [FFT_SAMPLES-1:0] frame_t;

endpackage

// File: rtl/sample_framer.sv
// Packs SAMPLES stream samples into a frame; out_valid one cycle after the last accept, then holds.
// in_ready drops only while a finished frame waits for the output slot. SAMPLE_FRAMER_FLUSH_EN adds zero-pad flush.
module sample_framer
    import fft_pkg::*;
#(
    parameter int SAMPLES = FFT_SAMPLES,
    parameter int WIDTH   = FFT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_sample,
`ifdef SAMPLE_FRAMER_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         frame_data [SAMPLES-1:0],
    output logic [$clog2(SAMPLES):0] fill_level
);

    localparam int              CW   = $clog2(SAMPLES) + 1;
    localparam int              IW   = CW - 1;
    localparam logic [CW-1:0]   FULL = CW'(SAMPLES);
    localparam logic [CW-1:0]   LAST = CW'(SAMPLES - 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] fill_buf_q [SAMPLES-1:0];
    logic [WIDTH-1:0] fill_buf_d [SAMPLES-1:0];
    logic [WIDTH-1:0] frame_q    [SAMPLES-1:0];
    logic [WIDTH-1:0] frame_d    [SAMPLES-1:0];
    logic [WIDTH-1:0] asm_frame  [SAMPLES-1:0];
    logic             out_valid_q, out_valid_d;

    logic filling, held, accept, slot_free, flush_take, complete, transfer;

    assign filling   = (cnt_q != FULL);
    assign held      = (cnt_q == FULL);
    assign accept    = in_valid & filling;
    assign slot_free = ~out_valid_q | out_ready;

`ifdef SAMPLE_FRAMER_FLUSH_EN
    // A sample accepted alongside the flush counts toward the flushed frame.
    assign flush_take = flush & filling & ((cnt_q != '0) | accept);
`else
    assign flush_take = 1'b0;
`endif

    assign complete = (accept & (cnt_q == LAST)) | flush_take;
    assign transfer = (complete | held) & slot_free;

    // Frame as it stands after this cycle's accept; entries past the fill point are zero.
    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            asm_frame[i] = '0;
            if (CW'(i) < cnt_q) begin
                asm_frame[i] = fill_buf_q[i];
            end else if (accept && (CW'(i) == cnt_q)) begin
                asm_frame[i] = in_sample;
            end
        end
    end

    always_comb begin
        fill_buf_d = fill_buf_q;
        cnt_d      = cnt_q;
        if (complete) begin
            fill_buf_d = asm_frame;
            cnt_d      = slot_free ? '0 : FULL;
        end else if (held) begin
            if (slot_free) begin
                cnt_d = '0;
            end
        end else if (accept) begin
            fill_buf_d[cnt_q[IW-1:0]] = in_sample;
            cnt_d                     = cnt_q + 1'b1;
        end
    end

    always_comb begin
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        if (transfer) begin
            frame_d     = held ? fill_buf_q : asm_frame;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            fill_buf_q <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            fill_buf_q <= fill_buf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            frame_q     <= '{default: '0};
        end else begin
            out_valid_q <= out_valid_d;
            frame_q     <= frame_d;
        end
    end

    assign in_ready   = filling;
    assign out_valid  = out_valid_q;
    assign frame_data = frame_q;
    assign fill_level = cnt_q;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer at SAMPLES=4, WIDTH=8: vector table for handshake state, scoreboard for frame contents.
module tb_sample_framer;

    localparam int S = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sample;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     frame_data [S-1:0];
    logic [$clog2(S):0] fill_level;

    always #5 clk = ~clk;

    sample_framer #(.SAMPLES(S), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
`ifdef SAMPLE_FRAMER_FLUSH_EN
        .flush      (flush),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_data (frame_data),
        .fill_level (fill_level)
    );

    typedef struct {
        logic       vld;
        logic [7:0] smp;
        logic       rdy;
        logic       exp_ir;
        logic       exp_ov;
        logic [2:0] exp_fill;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] expq[$];
    logic [7:0]  mbuf[$];
    logic [31:0] mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    int          frames_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic vld, input logic [7:0] smp, input logic rdy,
                       input logic ir, input logic ov, input logic [2:0] fl);
        vec_t v;
        v.vld = vld; v.smp = smp; v.rdy = rdy;
        v.exp_ir = ir; v.exp_ov = ov; v.exp_fill = fl;
        vecs.push_back(v);
    endtask

    // One clock: drive inputs, update the reference framer, advance to just past the edge.
    task automatic cyc(input logic vld, input logic [7:0] smp, input logic rdy, input logic fl);
        in_valid  = vld;
        in_sample = smp;
        out_ready = rdy;
        flush     = fl;
        if (vld && in_ready) mbuf.push_back(smp);
`ifdef SAMPLE_FRAMER_FLUSH_EN
        if (fl && mbuf.size() > 0) begin
            while (mbuf.size() < S) mbuf.push_back(8'h00);
        end
`endif
        if (mbuf.size() == S) begin
            expq.push_back({mbuf[3], mbuf[2], mbuf[1], mbuf[0]});
            mbuf.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ir, input logic ov, input logic [2:0] fl);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".fill_level"}, 32'(fill_level), 32'(fl));
    endtask

    // Frame handshakes complete on the following rising edge; compare mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            frames_seen++;
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: got %0h %0h %0h %0h, expected no frame",
                         frame_data[0], frame_data[1], frame_data[2], frame_data[3]);
            end else begin
                mon_e = expq.pop_front();
                for (int i = 0; i < S; i++) begin
                    chk($sformatf("frame_data[%0d]", i), 32'(frame_data[i]), 32'(mon_e[i*8 +: 8]));
                end
            end
        end
    end

    initial begin
        // Single frame, consumer ready.
        add(1, 8'h10, 1, 1, 0, 1);
        add(1, 8'h11, 1, 1, 0, 2);
        add(1, 8'h12, 1, 1, 0, 3);
        add(1, 8'h13, 1, 1, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0);
        // Back-to-back frames: no bubble, in_ready never drops.
        for (int k = 0; k < 12; k++) begin
            add(1, 8'(k), 1, 1, (k % 4) == 3, 3'((k + 1) % 4));
        end
        add(0, 8'h00, 1, 1, 0, 0);
        // Stalled consumer: second frame parks in HELD, then drains.
        add(1, 8'h20, 0, 1, 0, 1);
        add(1, 8'h21, 0, 1, 0, 2);
        add(1, 8'h22, 0, 1, 0, 3);
        add(1, 8'h23, 0, 1, 1, 0);
        add(1, 8'h24, 0, 1, 1, 1);
        add(1, 8'h25, 0, 1, 1, 2);
        add(1, 8'h26, 0, 1, 1, 3);
        add(1, 8'h27, 0, 0, 1, 4);
        add(1, 8'h28, 0, 0, 1, 4);
        add(0, 8'h00, 1, 1, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0);

        rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0; flush = 1'b0;
        #2;
        chk_state("reset", 1, 0, 0);
        for (int i = 0; i < S; i++) chk($sformatf("reset.frame_data[%0d]", i), 32'(frame_data[i]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 8'h00, 0, 0);
        chk_state("idle", 1, 0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            cyc(vecs[n].vld, vecs[n].smp, vecs[n].rdy, 1'b0);
            chk_state($sformatf("vec%0d", n), vecs[n].exp_ir, vecs[n].exp_ov, vecs[n].exp_fill);
        end
        chk("frames_after_table", 32'(frames_seen), 32'd6);

        // Async reset with a presented frame and a partial frame outstanding.
        cyc(1, 8'h31, 0, 0); cyc(1, 8'h32, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h34, 0, 0);
        cyc(1, 8'h55, 0, 0); cyc(1, 8'h66, 0, 0);
        chk_state("pre_reset", 1, 1, 2);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_reset", 1, 0, 0);
        for (int i = 0; i < S; i++) chk($sformatf("async_reset.frame_data[%0d]", i), 32'(frame_data[i]), 32'h0);
        expq.delete();
        mbuf.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1, 8'hA0, 1, 0); cyc(1, 8'hA1, 1, 0); cyc(1, 8'hA2, 1, 0); cyc(1, 8'hA3, 1, 0);
        chk_state("post_reset_frame", 1, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk_state("post_reset_idle", 1, 0, 0);

`ifdef SAMPLE_FRAMER_FLUSH_EN
        cyc(1, 8'h21, 1, 0); cyc(1, 8'h22, 1, 0);
        cyc(0, 8'h00, 1, 1);
        chk_state("flush_frame", 1, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk_state("flush_done", 1, 0, 0);
        cyc(0, 8'h00, 1, 1);
        chk_state("flush_empty", 1, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk_state("flush_empty_next", 1, 0, 0);
        cyc(1, 8'h41, 1, 0);
        cyc(1, 8'h42, 1, 1);
        chk_state("flush_with_accept", 1, 1, 0);
        cyc(0, 8'h00, 1, 0);
`endif

        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
